rr_bus_arbiter: RTL

//  Round-robin arbiter sharing one bus interface (modport sys) among N_REQ requesters.

---
 rtl/rr_bus_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter that hands one shared bus to one of N_REQ
// requesters at a time. Its one-hot grant drives the bus mux select.
//
// An owner keeps the bus until it drops its request, or until it has held the
// bus for MAX_HOLD cycles. A fixed turnaround of GAP then IDLE separates owners.
//
// Ports
//   clk      in   1             rising-edge clock
//   rst      in   1             asynchronous, active-high reset
//   req      in   N_REQ         level request per requester
//   grant    out  N_REQ         one-hot grant, or all-zero
//   gnt_idx  out  clog2(N_REQ)  index of current owner, valid when busy=1
//   busy     out  1             bus is owned (|grant)
//   timeout  out  1             one-cycle pulse when a tenure is cut at MAX_HOLD
module rr_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   gnt_idx,
    output logic                       busy,
    output logic                       timeout
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_cnt_d;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   last_d;
    logic [N_REQ-1:0]   grant_d;
    logic [IDX_W-1:0]   gnt_idx_d;
    logic               timeout_d;

    logic [IDX_W-1:0]   win;
    logic               win_found;
    int unsigned        scan;

    // Round-robin pick: first requester after 'last', wrapping modulo N_REQ.
    always_comb begin : pick_winner
        win       = '0;
        win_found = 1'b0;
        scan      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            scan = (32'(last) + i) % N_REQ;
            if (!win_found && req[IDX_W'(scan)]) begin
                win       = IDX_W'(scan);
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_logic
        state_d    = state;
        hold_cnt_d = hold_cnt;
        last_d     = last;
        grant_d    = grant;
        gnt_idx_d  = gnt_idx;
        timeout_d  = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    gnt_idx_d    = win;
                    last_d       = win;
                    hold_cnt_d   = '0;
                    state_d      = OWN;
                end
            end
            OWN: begin
                // A release wins over the cap, so a same-cycle drop never flags timeout.
                if (!req[gnt_idx]) begin
                    grant_d = '0;
                    state_d = GAP;
                end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    hold_cnt_d = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= IDX_W'(N_REQ - 1);
            grant    <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
            last     <= last_d;
            grant    <= grant_d;
            gnt_idx  <= gnt_idx_d;
            busy     <= |grant_d;
            timeout  <= timeout_d;
        end
    end

endmodule
